// File: rtl/if_redirect_unit.sv
// Fetch PC owner: applies EX redirects, holds on stalls, discards wrong-path fetches.
// Optional REDIRECT_STATS_EN adds saturating redirect/discard counters.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module if_redirect_unit #(
    parameter logic [`PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [`PC_WIDTH-1:0] PC_STEP  = `PC_WIDTH'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_change_pc,
    input  logic [`PC_WIDTH-1:0] i_alu_pc,
    input  logic                 i_stall,
    input  logic                 i_imem_ready,
    output logic [`PC_WIDTH-1:0] o_pc,
    output logic [`PC_WIDTH-1:0] o_pc_plus4,
    output logic                 o_imem_req,
    output logic                 o_fetch_valid,
    output logic                 o_flush_ifid,
    output logic                 o_flush_idex
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]          o_redirect_cnt,
    output logic [31:0]          o_discard_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DISCARD
    } state_t;

    state_t               r_state;
    logic [`PC_WIDTH-1:0] r_pc;
    logic [`PC_WIDTH-1:0] r_pending_pc;
    logic [`PC_WIDTH-1:0] w_pc_seq;
    logic                 w_active;

    assign w_active      = (r_state != S_BOOT);
    assign w_pc_seq      = r_pc + PC_STEP;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_seq;
    assign o_imem_req    = w_active;
    assign o_flush_ifid  = i_change_pc & w_active;
    assign o_flush_idex  = i_change_pc & w_active;
    assign o_fetch_valid = (r_state == S_RUN) & ~i_change_pc
                         & ~i_stall & i_imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
        end else begin
            unique case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (i_change_pc) begin
                        if (i_imem_ready) begin
                            r_pc <= i_alu_pc;
                        end else begin
                            // fetch in flight: o_pc must hold until it returns
                            r_pending_pc <= i_alu_pc;
                            r_state      <= S_DISCARD;
                        end
                    end else if (!i_stall && i_imem_ready) begin
                        r_pc <= w_pc_seq;
                    end
                end
                S_DISCARD: begin
                    if (i_change_pc) begin
                        r_pending_pc <= i_alu_pc;
                    end
                    if (i_imem_ready) begin
                        r_pc    <= i_change_pc ? i_alu_pc : r_pending_pc;
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_redirect_cnt <= '0;
            o_discard_cnt  <= '0;
        end else begin
            if (i_change_pc && w_active && (o_redirect_cnt != '1)) begin
                o_redirect_cnt <= o_redirect_cnt + 32'd1;
            end
            if ((r_state == S_RUN) && i_change_pc && !i_imem_ready
                && (o_discard_cnt != '1)) begin
                o_discard_cnt <= o_discard_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_redirect_unit.sv
// Bench for if_redirect_unit: per-cycle expectations queued at drive time,
// popped and compared just before the next rising edge.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_if_redirect_unit;

    logic                 clk;
    logic                 rst;
    logic                 i_change_pc;
    logic [`PC_WIDTH-1:0] i_alu_pc;
    logic                 i_stall;
    logic                 i_imem_ready;
    logic [`PC_WIDTH-1:0] o_pc;
    logic [`PC_WIDTH-1:0] o_pc_plus4;
    logic                 o_imem_req;
    logic                 o_fetch_valid;
    logic                 o_flush_ifid;
    logic                 o_flush_idex;
`ifdef REDIRECT_STATS_EN
    logic [31:0]          o_redirect_cnt;
    logic [31:0]          o_discard_cnt;
`endif

    typedef struct {
        logic [`PC_WIDTH-1:0] pc;
        logic                 req;
        logic                 fv;
        logic                 fl;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_pass;

    if_redirect_unit dut (
        .clk           (clk),
        .rst           (rst),
        .i_change_pc   (i_change_pc),
        .i_alu_pc      (i_alu_pc),
        .i_stall       (i_stall),
        .i_imem_ready  (i_imem_ready),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_imem_req    (o_imem_req),
        .o_fetch_valid (o_fetch_valid),
        .o_flush_ifid  (o_flush_ifid),
        .o_flush_idex  (o_flush_idex)
`ifdef REDIRECT_STATS_EN
        ,
        .o_redirect_cnt(o_redirect_cnt),
        .o_discard_cnt (o_discard_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic chg,
                        input logic [31:0] tgt, input logic stl,
                        input logic rdy, input logic [31:0] epc,
                        input logic ereq, input logic efv,
                        input logic efl);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst          = r;
        i_change_pc  = chg;
        i_alu_pc     = tgt;
        i_stall      = stl;
        i_imem_ready = rdy;
        e.pc  = epc;
        e.req = ereq;
        e.fv  = efv;
        e.fl  = efl;
        q.push_back(e);
        #4;
        g = q.pop_front();
        chk("pc", o_pc, g.pc);
        chk("pc_plus4", o_pc_plus4, g.pc + 32'd4);
        chk("imem_req", {31'd0, o_imem_req}, {31'd0, g.req});
        chk("fetch_valid", {31'd0, o_fetch_valid}, {31'd0, g.fv});
        chk("flush_ifid", {31'd0, o_flush_ifid}, {31'd0, g.fl});
        chk("flush_idex", {31'd0, o_flush_idex}, {31'd0, g.fl});
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst          = 1'b1;
        i_change_pc  = 1'b0;
        i_alu_pc     = '0;
        i_stall      = 1'b0;
        i_imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        // reset/BOOT ignores redirect
        step(1, 1, 32'h99, 0, 1, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 32'h4, 1, 1, 0);
        step(0, 0, 0, 0, 1, 32'h8, 1, 1, 0);
        step(0, 0, 0, 0, 1, 32'hC, 1, 1, 0);
        // taken branch
        step(0, 1, 32'h40, 0, 1, 32'h10, 1, 0, 1);
        step(0, 0, 0, 0, 1, 32'h40, 1, 1, 0);
        step(0, 1, 32'h20, 0, 1, 32'h44, 1, 0, 1);
        // stall three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 32'h20, 1, 0, 0);
        end
        step(0, 0, 0, 0, 1, 32'h20, 1, 1, 0);
        step(0, 1, 32'h30, 0, 1, 32'h24, 1, 0, 1);
        // discard path, stall ignored while discarding
        step(0, 1, 32'h80, 0, 0, 32'h30, 1, 0, 1);
        step(0, 0, 0, 0, 0, 32'h30, 1, 0, 0);
        step(0, 0, 0, 1, 0, 32'h30, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h30, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h80, 1, 1, 0);
        // last redirect wins in DISCARD, coinciding with ready
        step(0, 1, 32'h100, 0, 0, 32'h84, 1, 0, 1);
        step(0, 1, 32'h200, 0, 0, 32'h84, 1, 0, 1);
        step(0, 1, 32'h300, 0, 1, 32'h84, 1, 0, 1);
        // redirect beats stall, then wrap
        step(0, 1, 32'hFFFFFFFC, 1, 1, 32'h300, 1, 0, 1);
        step(0, 0, 0, 0, 1, 32'hFFFFFFFC, 1, 1, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
        // unaligned target loaded unmasked
        step(0, 1, 32'h13, 0, 1, 32'h4, 1, 0, 1);
        step(0, 0, 0, 0, 1, 32'h13, 1, 1, 0);
        // reset while in DISCARD drops pending target
        step(0, 1, 32'h500, 0, 0, 32'h17, 1, 0, 1);
        step(1, 0, 0, 0, 0, 32'h17, 1, 0, 0);
`ifdef REDIRECT_STATS_EN
        chk("redirect_cnt", o_redirect_cnt, 32'd10);
        chk("discard_cnt", o_discard_cnt, 32'd3);
`endif
        step(0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
`ifdef REDIRECT_STATS_EN
        chk("redirect_cnt_rst", o_redirect_cnt, 32'd0);
        chk("discard_cnt_rst", o_discard_cnt, 32'd0);
`endif
        step(0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 32'h4, 1, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
